// File: rtl/lab_pkg.sv
// Shared constants and the switch-to-step decode used by the lab counter blocks.
package lab_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int SW_UP  = 0;
    localparam int SW_DN  = 1;

    localparam int CLK_HZ = 125_000_000;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_e;

    // Both switches pressed is a hold, never an up-then-down.
    function automatic step_e decode_step(input logic [1:0] sw);
        step_e step;
        if (sw[SW_UP] && !sw[SW_DN]) begin
            step = STEP_UP;
        end else if (sw[SW_DN] && !sw[SW_UP]) begin
            step = STEP_DN;
        end else begin
            step = STEP_HOLD;
        end
        return step;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler producing a registered one-cycle enable.
module tick_prescaler #(
    parameter int DIV   = lab_pkg::CLK_HZ,
    parameter int DIV_W = 27
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam logic [DIV_W-1:0] PSC_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PSC_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] psc_q;
    logic [DIV_W-1:0] psc_d;
    logic             tick_q;
    logic             tick_d;

    // Next prescaler phase; the tick is raised for the cycle after the last phase.
    always_comb begin
        psc_d  = psc_q;
        tick_d = 1'b0;
        if (psc_q == PSC_LAST) begin
            psc_d  = '0;
            tick_d = 1'b1;
        end else begin
            psc_d  = psc_q + PSC_ONE;
            tick_d = 1'b0;
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            psc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            tick_q <= tick_d;
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/updown_counter_param.sv
// Switch-driven up/down LED counter with wrap/saturate modes, parallel load
// and a terminal-count pulse, stepping on an internal prescaler tick.
module updown_counter_param
    import lab_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = CLK_HZ,
    parameter int DIV_W = 27
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       SWITCHES,
    input  logic             MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] LEDS,
    output logic             TICK,
    output logic             TC
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [1:0]       sw_meta_q;
    logic [1:0]       sw_s_q;
    logic [WIDTH-1:0] leds_q;
    logic [WIDTH-1:0] leds_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick_s;
    step_e            step_s;

    tick_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (tick_s)
    );

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sw_meta_q <= 2'b00;
            sw_s_q    <= 2'b00;
        end else begin
            sw_meta_q <= SWITCHES;
            sw_s_q    <= sw_meta_q;
        end
    end

    // Next count: load beats any step; a step only happens on a tick and
    // flags TC when it wraps or is blocked at a limit.
    always_comb begin
        leds_d = leds_q;
        tc_d   = 1'b0;
        step_s = decode_step(sw_s_q);
        if (LOAD) begin
            leds_d = LOAD_VAL;
        end else if (tick_s) begin
            case (step_s)
                STEP_UP: begin
                    if (leds_q == CNT_MAX) begin
                        tc_d   = 1'b1;
                        leds_d = (MODE == MODE_WRAP) ? CNT_ZERO : leds_q;
                    end else begin
                        leds_d = leds_q + CNT_ONE;
                    end
                end
                STEP_DN: begin
                    if (leds_q == CNT_ZERO) begin
                        tc_d   = 1'b1;
                        leds_d = (MODE == MODE_WRAP) ? CNT_MAX : leds_q;
                    end else begin
                        leds_d = leds_q - CNT_ONE;
                    end
                end
                default: begin
                    leds_d = leds_q;
                end
            endcase
        end else begin
            leds_d = leds_q;
        end
    end

    // Counter and terminal-count registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            leds_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            leds_q <= leds_d;
            tc_q   <= tc_d;
        end
    end

    assign LEDS = leds_q;
    assign TC   = tc_q;
    assign TICK = tick_s;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param with DIV=4, WIDTH=4.
module tb_updown_counter_param;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int DIV_W = 3;
    localparam int NVEC  = 18;

    logic             CLK;
    logic             RESET;
    logic [1:0]       SWITCHES;
    logic             MODE;
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_VAL;
    logic [WIDTH-1:0] LEDS;
    logic             TICK;
    logic             TC;

    int n_chk;
    int n_pass;

    typedef struct {
        logic             do_load;
        logic [WIDTH-1:0] load_val;
        logic [1:0]       sw;
        logic             mode;
        logic [WIDTH-1:0] exp_leds;
        logic             exp_tc;
    } vec_t;

    vec_t vecs [NVEC];

    updown_counter_param #(
        .WIDTH (WIDTH),
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SWITCHES (SWITCHES),
        .MODE     (MODE),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .LEDS     (LEDS),
        .TICK     (TICK),
        .TC       (TC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at a negedge where TICK is high, or flags a timeout.
    task automatic wait_tick(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (TICK === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge CLK);
        end
        if (found == 0) begin
            chk({name, "_tick_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_step(input string name, input logic [WIDTH-1:0] exp_leds, input logic exp_tc);
        wait_tick(name);
        @(negedge CLK);
        chk({name, "_leds"}, 32'(LEDS), 32'(exp_leds));
        chk({name, "_tc"}, 32'(TC), 32'(exp_tc));
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        LOAD     = 1'b1;
        LOAD_VAL = v;
        @(negedge CLK);
        LOAD     = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        RESET    = 1'b0;
        SWITCHES = 2'b00;
        MODE     = 1'b0;
        LOAD     = 1'b0;
        LOAD_VAL = '0;

        //               load  val    sw     mode  leds   tc
        vecs[0]  = '{1'b1, 4'd14, 2'b01, 1'b0, 4'd14, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  2'b01, 1'b0, 4'd15, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  2'b01, 1'b0, 4'd0,  1'b1};
        vecs[3]  = '{1'b0, 4'd0,  2'b01, 1'b0, 4'd1,  1'b0};
        vecs[4]  = '{1'b1, 4'd1,  2'b10, 1'b1, 4'd1,  1'b0};
        vecs[5]  = '{1'b0, 4'd0,  2'b10, 1'b1, 4'd0,  1'b0};
        vecs[6]  = '{1'b0, 4'd0,  2'b10, 1'b1, 4'd0,  1'b1};
        vecs[7]  = '{1'b0, 4'd0,  2'b10, 1'b1, 4'd0,  1'b1};
        vecs[8]  = '{1'b0, 4'd0,  2'b10, 1'b0, 4'd15, 1'b1};
        vecs[9]  = '{1'b0, 4'd0,  2'b11, 1'b0, 4'd15, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  2'b11, 1'b0, 4'd15, 1'b0};
        vecs[11] = '{1'b0, 4'd0,  2'b11, 1'b0, 4'd15, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  2'b00, 1'b0, 4'd15, 1'b0};
        vecs[13] = '{1'b0, 4'd0,  2'b00, 1'b0, 4'd15, 1'b0};
        vecs[14] = '{1'b0, 4'd0,  2'b00, 1'b0, 4'd15, 1'b0};
        vecs[15] = '{1'b1, 4'd14, 2'b01, 1'b1, 4'd14, 1'b0};
        vecs[16] = '{1'b0, 4'd0,  2'b01, 1'b1, 4'd15, 1'b0};
        vecs[17] = '{1'b0, 4'd0,  2'b01, 1'b1, 4'd15, 1'b1};

        // Reset held, then released at a negedge; TICK on edges 4 and 8.
        repeat (5) @(negedge CLK);
        chk("rst_leds", 32'(LEDS), 32'd0);
        chk("rst_tc", 32'(TC), 32'd0);
        chk("rst_tick", 32'(TICK), 32'd0);
        RESET = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge CLK);
            chk($sformatf("rel_tick_e%0d", e), 32'(TICK), ((e % DIV) == 0) ? 32'd1 : 32'd0);
        end
        chk("rel_leds", 32'(LEDS), 32'd0);

        // Table-driven stepping.
        for (int i = 0; i < NVEC; i++) begin
            SWITCHES = vecs[i].sw;
            MODE     = vecs[i].mode;
            if (vecs[i].do_load) begin
                repeat (3) @(negedge CLK);
                do_load(vecs[i].load_val);
                chk($sformatf("v%0d_load_leds", i), 32'(LEDS), 32'(vecs[i].exp_leds));
                chk($sformatf("v%0d_load_tc", i), 32'(TC), 32'(vecs[i].exp_tc));
            end else begin
                check_step($sformatf("v%0d", i), vecs[i].exp_leds, vecs[i].exp_tc);
            end
        end

        // Load coinciding with a tick: step discarded, no TC.
        MODE     = 1'b0;
        SWITCHES = 2'b01;
        repeat (3) @(negedge CLK);
        wait_tick("coll");
        do_load(4'd9);
        chk("coll_leds", 32'(LEDS), 32'd9);
        chk("coll_tc", 32'(TC), 32'd0);
        check_step("coll_next", 4'd10, 1'b0);

        // Asynchronous reset between edges, then phase restarts from 0.
        do_load(4'd7);
        chk("arst_pre_leds", 32'(LEDS), 32'd7);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_leds", 32'(LEDS), 32'd0);
        chk("arst_tc", 32'(TC), 32'd0);
        chk("arst_tick", 32'(TICK), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge CLK);
            chk($sformatf("arst_tick_e%0d", e), 32'(TICK), (e == DIV) ? 32'd1 : 32'd0);
        end
        chk("arst_first_step", 32'(LEDS), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down LED counter, next generation of the lab switch-driven counter.
- Counter width is generic; count rate comes from an internal prescaler tick. No derived clock: all logic runs on CLK.
- Adds switch synchronisers, wrap/saturate mode, parallel load and a terminal-count pulse.
- Sits between board switches/buttons and the LED bank.

Parameters:
- WIDTH, 4, counter and LED width in bits (>=2).
- DIV, 125_000_000, CLK cycles per count step (>=2); 125_000_000 gives 1 step/s at 125 MHz.
- DIV_W, 27, prescaler width; must satisfy 2**DIV_W >= DIV.

Ports:
- CLK  in  1  system clock; all state on posedge.
- RESET  in  1  asynchronous, active-low reset; clears all state immediately.
- SWITCHES  in  2  [0]=count up, [1]=count down; asynchronous board inputs.
- MODE  in  1  0=wrap, 1=saturate; quasi-static, sampled on the tick cycle.
- LOAD  in  1  synchronous parallel-load strobe; already synchronous to CLK.
- LOAD_VAL  in  WIDTH  value loaded when LOAD=1.
- LEDS  out  WIDTH  registered counter value.
- TICK  out  1  one-cycle prescaler pulse, for debug/chaining.
- TC  out  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset (RESET=0) clears LEDS, TICK, TC, the prescaler and both synchroniser stages to 0. Release is asynchronous assert, used directly.
- Prescaler:
  - psc counts 0..DIV-1, then returns to 0.
  - TICK=1 registered in the cycle after psc==DIV-1. Period is exactly DIV cycles.
  - After reset release, the first TICK appears on cycle DIV.
- Synchronisers: SWITCHES pass through a 2-flop synchroniser, giving 2 cycles latency to sw_s[1:0]. The counter uses only sw_s.
- Step decision, only in cycles where TICK=1:
  - sw_s=01: up. sw_s=10: down.
  - sw_s=00 or 11: hold. Both pressed is defined as hold, not up-then-down.
- Wrap mode (MODE=0):
  - up from 2**WIDTH-1 -> 0; down from 0 -> 2**WIDTH-1; modulo arithmetic.
- Saturate mode (MODE=1):
  - up at 2**WIDTH-1 holds; down at 0 holds.
- TC:
  - Asserted for exactly one cycle, in the same cycle LEDS updates, when a step wraps (MODE=0) or is blocked at a limit (MODE=1).
  - Hold steps never assert TC.
- LOAD:
  - Highest priority after reset. LEDS<=LOAD_VAL on the next edge, whether or not TICK=1.
  - A coincident step is discarded and TC=0 that cycle.
  - Prescaler phase is unaffected by LOAD.
- LEDS update latency: one cycle after the TICK=1 cycle. Switch-to-LED latency is up to 2 sync cycles + DIV + 1.
- Reset mid-count: outputs clear immediately. No partial step or TC survives.
- MODE changes between ticks take effect at the next tick. No state is kept per mode.

Decomposition:
- Shared package lab_pkg:
  - MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - Switch bit indices SW_UP=0, SW_DN=1.
  - Default DIV constant CLK_HZ=125_000_000.
- Sub-module tick_prescaler:
  - Parameters DIV, DIV_W; ports CLK, RESET, TICK.
  - Reused by later lab blocks needing a slow enable.
- Counter/step logic and synchronisers stay in the top module.

Test Plan (DIV=4, WIDTH=4 for sim):
- Reset: hold RESET=0 for 5 cycles, release -> LEDS=0, TC=0; first TICK on cycle 4 after release, then every 4 cycles.
- Up/wrap: SWITCHES=01, MODE=0, LOAD_VAL=14 loaded -> LEDS 14,15,0,1 on successive ticks; TC=1 only with the 15->0 step.
- Down/saturate: MODE=1, load 1, SWITCHES=10 -> LEDS 1,0,0,0; TC=1 on each blocked step at 0; MODE=0 next tick -> LEDS=15, TC=1.
- Both/neither: SWITCHES=11 then 00 across 3 ticks each -> LEDS unchanged, TC never asserted.
- Load collision: LOAD=1 with LOAD_VAL=9 in a TICK cycle, SWITCHES=01 -> LEDS=9 (not 10), TC=0; next tick -> 10.
- Async reset mid-run: drop RESET between edges at LEDS=7 -> LEDS=0 before the next CLK edge; after release, TICK resumes from phase 0.
